// File: rtl/id_ctrl.sv
// Decode-stage controller: combinational instruction decode, load-use hazard
// detection with a one-entry load scoreboard, and a RUN/STALL/HALT sequencer.
module id_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      instr_in,
  input  logic             instr_valid,
  input  logic             flush,
  output logic             sw1_out,
  output logic             sw2_out,
  output logic             sw3_out,
  output logic             sw4_out,
  output logic             sw5_out,
  output logic             sw6_out,
  output logic [2:0]       rd_out,
  output logic             valid_out,
  output logic             stall_out,
  output logic             halt_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state, state_n;
  logic       ld_pend;
  logic [2:0] ld_rd;

  // Decoded fields; d_sw[0] is sw1 ... d_sw[5] is sw6.
  logic [5:0] d_sw;
  logic [2:0] d_rd;
  logic       use_a, use_b, is_hlt, hazard;
  logic [2:0] reg_a, reg_b;
  logic       unused_bits;

  logic       issue, stall_o, halt_o, cnt_inc;

  assign reg_a       = instr_in[13:11];
  assign reg_b       = instr_in[10:8];
  assign unused_bits = ^instr_in[3:0];

  always_comb begin
    d_sw   = 6'b000000;
    d_rd   = 3'd0;
    use_a  = 1'b0;
    use_b  = 1'b0;
    is_hlt = 1'b0;
    case (instr_in[15:14])
      2'b11: begin
        use_a = 1'b1;
        use_b = 1'b1;
        if (instr_in[7:4] == 4'hF) begin
          is_hlt = 1'b1;
        end else begin
          d_sw[3] = 1'b1;
          d_rd    = reg_b;
        end
      end
      2'b00: begin
        d_sw  = 6'b011011;
        d_rd  = reg_b;
        use_a = 1'b1;
      end
      2'b01: begin
        d_sw  = 6'b000101;
        use_a = 1'b1;
        use_b = 1'b1;
      end
      default: begin
        if (instr_in[13:11] == 3'b000) begin
          d_sw = 6'b001001;
          d_rd = reg_b;
        end else if (instr_in[13:11] == 3'b100 || instr_in[13:11] == 3'b111) begin
          d_sw[5] = 1'b1;
        end
      end
    endcase
  end

  assign hazard = ld_pend && ((use_a && reg_a == ld_rd) || (use_b && reg_b == ld_rd));

  always_comb begin
    state_n = RUN;
    issue   = 1'b0;
    stall_o = 1'b0;
    halt_o  = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      HALT: begin
        state_n = HALT;
        stall_o = 1'b1;
        halt_o  = 1'b1;
      end
      default: begin
        // Flush wins over everything, including a pending hazard or HLT.
        if (flush || !instr_valid) begin
          state_n = RUN;
        end else if (state == RUN && hazard) begin
          state_n = STALL;
          stall_o = 1'b1;
          cnt_inc = 1'b1;
        end else if (is_hlt) begin
          state_n = HALT;
        end else begin
          issue = 1'b1;
        end
      end
    endcase
    if (reset) begin
      issue   = 1'b0;
      stall_o = 1'b0;
      halt_o  = 1'b0;
      cnt_inc = 1'b0;
    end
  end

  assign sw1_out   = issue & d_sw[0];
  assign sw2_out   = issue & d_sw[1];
  assign sw3_out   = issue & d_sw[2];
  assign sw4_out   = issue & d_sw[3];
  assign sw5_out   = issue & d_sw[4];
  assign sw6_out   = issue & d_sw[5];
  assign rd_out    = issue ? d_rd : 3'd0;
  assign valid_out = issue;
  assign stall_out = stall_o;
  assign halt_out  = halt_o;
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      ld_pend   <= 1'b0;
      ld_rd     <= 3'd0;
      stall_cnt <= '0;
    end else begin
      state   <= state_n;
      ld_pend <= issue && d_sw[1];
      if (issue && d_sw[1]) begin
        ld_rd <= d_rd;
      end
      if (cnt_inc && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ctrl.sv
// Directed bench for id_ctrl: each cycle's expected outputs are queued by the
// driver and compared by a negedge monitor; a CNT_W=2 copy checks saturation.
module tb_id_ctrl;

  localparam int W = 22;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr_in = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;

  logic       sw1, sw2, sw3, sw4, sw5, sw6, valid_out, stall_out, halt_out;
  logic [2:0] rd_out;
  logic [7:0] cnt8;
  logic [1:0] state_dbg;

  logic       b_sw1, b_sw2, b_sw3, b_sw4, b_sw5, b_sw6, b_valid, b_stall, b_halt;
  logic [2:0] b_rd;
  logic [1:0] cnt2;
  logic [1:0] b_state_dbg;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests = 0;
  int           fails = 0;

  always #5 clock = ~clock;

  id_ctrl dut (
    .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .flush(flush), .sw1_out(sw1), .sw2_out(sw2), .sw3_out(sw3), .sw4_out(sw4),
    .sw5_out(sw5), .sw6_out(sw6), .rd_out(rd_out), .valid_out(valid_out),
    .stall_out(stall_out), .halt_out(halt_out), .stall_cnt(cnt8), .state_dbg(state_dbg)
  );

  id_ctrl #(.CNT_W(2)) dut_w2 (
    .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .flush(flush), .sw1_out(b_sw1), .sw2_out(b_sw2), .sw3_out(b_sw3), .sw4_out(b_sw4),
    .sw5_out(b_sw5), .sw6_out(b_sw6), .rd_out(b_rd), .valid_out(b_valid),
    .stall_out(b_stall), .halt_out(b_halt), .stall_cnt(cnt2), .state_dbg(b_state_dbg)
  );

  // Packed response: {valid, sw1..sw6, rd, stall, halt, cnt8, cnt2}.
  logic [W-1:0] act;
  assign act = {valid_out, sw1, sw2, sw3, sw4, sw5, sw6, rd_out, stall_out, halt_out, cnt8, cnt2};

  always @(negedge clock) begin
    logic [W-1:0] e;
    string        n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got v=%b sw=%b rd=%0d st=%b h=%b c8=%0d c2=%0d, want v=%b sw=%b rd=%0d st=%b h=%b c8=%0d c2=%0d",
                 n, act[21], act[20:15], act[14:12], act[11], act[10], act[9:2], act[1:0],
                 e[21], e[20:15], e[14:12], e[11], e[10], e[9:2], e[1:0]);
      end
    end
  end

  // esw is {sw1,sw2,sw3,sw4,sw5,sw6}.
  task automatic step(input logic rst, input logic [15:0] ins, input logic iv, input logic fl,
                      input logic ev, input logic [5:0] esw, input logic [2:0] erd,
                      input logic est, input logic eh, input logic [7:0] ec8,
                      input logic [1:0] ec2, input string nm);
    @(posedge clock);
    #1;
    reset       = rst;
    instr_in    = ins;
    instr_valid = iv;
    flush       = fl;
    exp_q.push_back({ev, esw, erd, est, eh, ec8, ec2});
    name_q.push_back(nm);
  endtask

  localparam logic [15:0] LD_R3  = 16'h0B00;  // LD ra=r1 rb=r3
  localparam logic [15:0] ADD_R3 = 16'hD300;  // ALU rs=r2 rd=r3
  localparam logic [15:0] ADD_R4 = 16'hD400;  // ALU rs=r2 rd=r4
  localparam logic [15:0] ST_A3  = 16'h5800;  // ST ra=r3 rb=r0
  localparam logic [15:0] ST_B3  = 16'h4300;  // ST ra=r0 rb=r3
  localparam logic [15:0] LI_R5  = 16'h8523;
  localparam logic [15:0] BR     = 16'hA000;
  localparam logic [15:0] BCC    = 16'hB800;
  localparam logic [15:0] HLT    = 16'hC0F0;

  initial begin
    //    rst  instr   iv fl  v  sw         rd st h  c8 c2
    step(1, LD_R3,  1, 0, 0, 6'b000000, 0, 0, 0, 0, 0, "reset_bubble");
    step(0, LD_R3,  1, 0, 1, 6'b110110, 3, 0, 0, 0, 0, "ld_issue");
    step(0, ADD_R3, 1, 0, 0, 6'b000000, 0, 1, 0, 0, 0, "loaduse_stall");
    step(0, ADD_R3, 1, 0, 1, 6'b000100, 3, 0, 0, 1, 1, "add_after_stall");
    step(0, LD_R3,  1, 0, 1, 6'b110110, 3, 0, 0, 1, 1, "ld_issue2");
    step(0, ADD_R4, 1, 0, 1, 6'b000100, 4, 0, 0, 1, 1, "indep_no_stall");
    step(0, LD_R3,  1, 0, 1, 6'b110110, 3, 0, 0, 1, 1, "ld_issue3");
    step(0, ST_A3,  1, 1, 0, 6'b000000, 0, 0, 0, 1, 1, "flush_over_hazard");
    step(0, ST_A3,  1, 0, 1, 6'b101000, 0, 0, 0, 1, 1, "st_after_flush");
    step(0, LI_R5,  1, 0, 1, 6'b100100, 5, 0, 0, 1, 1, "li_decode");
    step(0, BR,     1, 0, 1, 6'b000001, 0, 0, 0, 1, 1, "b_decode");
    step(0, BCC,    1, 0, 1, 6'b000001, 0, 0, 0, 1, 1, "bcc_decode");
    step(0, LD_R3,  0, 0, 0, 6'b000000, 0, 0, 0, 1, 1, "invalid_bubble");
    step(0, LD_R3,  1, 0, 1, 6'b110110, 3, 0, 0, 1, 1, "ld_issue4");
    step(0, LD_R3,  0, 0, 0, 6'b000000, 0, 0, 0, 1, 1, "invalid_after_ld");
    step(0, ADD_R3, 1, 0, 1, 6'b000100, 3, 0, 0, 1, 1, "pend_cleared_by_bubble");
    step(0, LD_R3,  1, 0, 1, 6'b110110, 3, 0, 0, 1, 1, "pair2_ld");
    step(0, ST_B3,  1, 0, 0, 6'b000000, 0, 1, 0, 1, 1, "pair2_st_rb_stall");
    step(0, ST_B3,  1, 0, 1, 6'b101000, 0, 0, 0, 2, 2, "pair2_st_issue");
    step(0, LD_R3,  1, 0, 1, 6'b110110, 3, 0, 0, 2, 2, "pair3_ld");
    step(0, ADD_R3, 1, 0, 0, 6'b000000, 0, 1, 0, 2, 2, "pair3_stall");
    step(0, ADD_R3, 1, 0, 1, 6'b000100, 3, 0, 0, 3, 3, "pair3_issue");
    step(0, LD_R3,  1, 0, 1, 6'b110110, 3, 0, 0, 3, 3, "pair4_ld");
    step(0, ADD_R3, 1, 0, 0, 6'b000000, 0, 1, 0, 3, 3, "pair4_stall");
    step(0, ADD_R3, 1, 0, 1, 6'b000100, 3, 0, 0, 4, 3, "pair4_saturate");
    step(0, LD_R3,  1, 0, 1, 6'b110110, 3, 0, 0, 4, 3, "pair5_ld");
    step(0, ADD_R3, 1, 0, 0, 6'b000000, 0, 1, 0, 4, 3, "pair5_stall");
    step(0, ADD_R3, 1, 1, 0, 6'b000000, 0, 0, 0, 5, 3, "flush_in_stall");
    step(0, ADD_R3, 1, 0, 1, 6'b000100, 3, 0, 0, 5, 3, "issue_after_stall_flush");
    step(0, LD_R3,  1, 0, 1, 6'b110110, 3, 0, 0, 5, 3, "pair6_ld");
    step(0, ADD_R3, 1, 0, 0, 6'b000000, 0, 1, 0, 5, 3, "pair6_stall");
    step(1, ADD_R3, 1, 0, 0, 6'b000000, 0, 0, 0, 6, 3, "reset_in_stall");
    step(0, ADD_R3, 1, 0, 1, 6'b000100, 3, 0, 0, 0, 0, "run_after_reset");
    step(0, HLT,    1, 1, 0, 6'b000000, 0, 0, 0, 0, 0, "flush_over_hlt");
    step(0, LI_R5,  1, 0, 1, 6'b100100, 5, 0, 0, 0, 0, "not_halted");
    step(0, HLT,    1, 0, 0, 6'b000000, 0, 0, 0, 0, 0, "hlt_bubble");
    step(0, LD_R3,  1, 1, 0, 6'b000000, 0, 1, 1, 0, 0, "halt_ignores_flush");
    step(0, LD_R3,  1, 0, 0, 6'b000000, 0, 1, 1, 0, 0, "halt_holds");
    step(1, LD_R3,  1, 0, 0, 6'b000000, 0, 0, 0, 0, 0, "reset_in_halt");
    step(0, LI_R5,  1, 0, 1, 6'b100100, 5, 0, 0, 0, 0, "run_after_halt_reset");

    repeat (3) @(negedge clock);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ctrl.md
ID_CTRL -- requirements
Module: id_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of stall-cycle counter.
REQ-002 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high; sampled only on rising clock edge.
REQ-004 SHALL have port: instr_in  input  16  instruction from IF/ID register.
REQ-005 SHALL have port: instr_valid  input  1  instr_in holds a real instruction.
REQ-006 SHALL have port: flush  input  1  branch taken in EX; kill current decode.
REQ-007 SHALL have port: sw1_out  output  1  ALU operand-B select immediate.
REQ-008 SHALL have port: sw2_out  output  1  memory read.
REQ-009 SHALL have port: sw3_out  output  1  memory write.
REQ-010 SHALL have port: sw4_out  output  1  register write.
REQ-011 SHALL have port: sw5_out  output  1  write-back source = memory.
REQ-012 SHALL have port: sw6_out  output  1  branch instruction.
REQ-013 SHALL have port: rd_out  output  3  destination register number.
REQ-014 SHALL have port: valid_out  output  1  sw*/rd_out describe a real instruction (0 = bubble).
REQ-015 SHALL have port: stall_out  output  1  hold IF/ID and PC this cycle.
REQ-016 SHALL have port: halt_out  output  1  processor halted.
REQ-017 SHALL have port: stall_cnt  output  CNT_W  count of load-use stall cycles.

Function
REQ-018 SHALL decode combinationally: [15:14]=11 ALU (rs=[13:11], rd=[10:8], op3=[7:4]); 00 LD (ra=[13:11], rb=[10:8]); 01 ST (ra, rb); 10 immediate/branch (op2=[13:11]).
REQ-019 SHALL drive controls: ALU sw4=1, rd_out=rd; LD sw1,sw2,sw4,sw5=1, rd_out=rb; ST sw1,sw3=1; LI (10,op2=000) sw1,sw4=1, rd_out=[10:8]; B/Bcc (10,op2=100/111) sw6=1; all other bits 0.
REQ-020 SHALL treat ALU op3=1111 as HLT: bubble issued, next state HALT.
REQ-021 SHALL define source reads: ALU reads rs and rd; LD reads ra; ST reads ra and rb; LI and branches read none.
REQ-022 SHALL keep a one-entry scoreboard {ld_pend, ld_rd}: on an edge where an LD issues (valid_out=1, sw2_out=1) load ld_pend=1, ld_rd=rd_out; on any other edge clear ld_pend.
REQ-023 SHALL implement states RUN, STALL, HALT; reset -> RUN.
REQ-024 In RUN, if instr_valid and ld_pend and any read register equals ld_rd: bubble, stall_out=1, next state STALL, stall_cnt+1.
REQ-025 In STALL: issue instruction normally (no re-check, ld_pend already cleared), stall_out=0, next RUN.
REQ-026 In HALT: bubble, stall_out=1, halt_out=1, stall_cnt frozen; only reset exits.
REQ-027 instr_valid=0 in RUN/STALL SHALL give bubble, stall_out=0, next RUN.
REQ-028 flush=1 in RUN/STALL SHALL override hazard and HLT: bubble, stall_out=0, ld_pend cleared, next RUN, no counter increment; flush ignored in HALT.
REQ-029 Bubble SHALL mean sw1..sw6=0, rd_out=0, valid_out=0.
REQ-030 stall_cnt SHALL saturate at all-ones.
REQ-031 Decode outputs SHALL be zero-latency (same cycle as instr_in); state, scoreboard, counter update on the rising edge.

Reset
REQ-032 reset=1 at an edge SHALL force RUN, ld_pend=0, ld_rd=0, stall_cnt=0 regardless of state, including HALT and STALL.
REQ-033 While reset=1, outputs SHALL show bubble, stall_out=0, halt_out=0.

Verification
REQ-034 LD r3<-[r1] then ADD rd=r3 -> cycle 2 bubble, stall_out=1; cycle 3 ADD issued valid_out=1, sw4=1, rd_out=3; stall_cnt=1.
REQ-035 LD rb=r3 then ADD rs=r2,rd=r4 -> no stall; ADD issued next cycle, stall_cnt=0.
REQ-036 LD rb=r3 then ST ra=r3 with flush=1 same cycle -> bubble, stall_out=0, stall_cnt=0, next instruction issues normally.
REQ-037 HLT (0xC0F0) -> bubble; following cycles halt_out=1, stall_out=1 with flush=1 applied; reset -> halt_out=0, RUN.
REQ-038 CNT_W=2, four load-use pairs -> stall_cnt sequence 1,2,3,3.
REQ-039 reset asserted while in STALL -> next cycle RUN, stall_cnt=0, dependent instruction issues without stall.
